// File: rtl/itrx_aib_phy_io_buf_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// itrx_aib_phy_io_buf_seq : glitch-safe mode sequencer for one AIB IO pad
// Rev 1.0
// ---------------------------------------------------------------------------
module itrx_aib_phy_io_buf_seq #(
  parameter int         DLY_W    = 8,
  parameter logic [2:0] RXEN_OFF = 3'b000,
  parameter logic [2:0] RXEN_DAT = 3'b001,
  parameter logic [2:0] RXEN_CLK = 3'b010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             por_vcc_io_i,
  input  logic             por_vcc_dig_i,
  input  logic             mode_req_i,
  input  logic [1:0]       mode_sel_i,
  input  logic [DLY_W-1:0] settle_cyc_i,
  input  logic             wkpu_cfg_i,
  input  logic             wkpd_cfg_i,
  input  logic [3:0]       drv_cfg_i,
  output logic             txen_o,
  output logic [2:0]       rxen_o,
  output logic             iweakpu_o,
  output logic             iweakpdn_o,
  output logic [1:0]       ipdrv_o,
  output logic [1:0]       indrv_o,
  output logic             tx_irstb_o,
  output logic             rx_irstb_o,
  output logic             mode_ack_o,
  output logic             busy_o,
  output logic [1:0]       cur_mode_o
);

  localparam logic [1:0] C_MODE_OFF = 2'b00;
  localparam logic [1:0] C_MODE_TX  = 2'b01;
  localparam logic [1:0] C_MODE_RXD = 2'b10;

  typedef enum logic [2:0] {
    S_POR, S_PWRUP, S_OFF, S_QUIESCE, S_ENABLE, S_RELEASE, S_ACTIVE
  } state_e;

  state_e           state_q;
  logic             req_q;
  logic [1:0]       tgt_q;
  logic [DLY_W-1:0] cnt_q;

  logic             w_req_edge;
  logic             w_por;
  logic             w_wkpu;
  logic             w_wkpd;
  logic [DLY_W-1:0] w_n_load;

  assign w_req_edge = mode_req_i & ~req_q;
  assign w_por      = por_vcc_io_i | por_vcc_dig_i;
  assign w_wkpu     = wkpu_cfg_i;
  assign w_wkpd     = wkpd_cfg_i & ~wkpu_cfg_i;
  // Counter holds N-1 so the step ends exactly N edges after the load.
  assign w_n_load   = (settle_cyc_i == '0) ? '0 : settle_cyc_i - 1'b1;

  always_ff @(posedge clk) begin
    req_q      <= rst ? 1'b0 : mode_req_i;
    mode_ack_o <= 1'b0;
    if (rst || w_por) begin
      state_q    <= S_POR;
      tgt_q      <= C_MODE_OFF;
      cnt_q      <= '0;
      txen_o     <= 1'b0;
      rxen_o     <= RXEN_OFF;
      iweakpu_o  <= 1'b0;
      iweakpdn_o <= 1'b0;
      ipdrv_o    <= 2'b00;
      indrv_o    <= 2'b00;
      tx_irstb_o <= 1'b0;
      rx_irstb_o <= 1'b0;
      busy_o     <= 1'b1;
      cur_mode_o <= C_MODE_OFF;
    end else begin
      case (state_q)
        S_POR: begin
          state_q <= S_PWRUP;
          cnt_q   <= w_n_load;
        end
        S_PWRUP: begin
          if (cnt_q == '0) begin
            state_q    <= S_OFF;
            busy_o     <= 1'b0;
            iweakpu_o  <= w_wkpu;
            iweakpdn_o <= w_wkpd;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_OFF, S_ACTIVE: begin
          if (cur_mode_o == C_MODE_TX) begin
            iweakpu_o  <= 1'b0;
            iweakpdn_o <= 1'b0;
            ipdrv_o    <= drv_cfg_i[3:2];
            indrv_o    <= drv_cfg_i[1:0];
          end else begin
            iweakpu_o  <= w_wkpu;
            iweakpdn_o <= w_wkpd;
            ipdrv_o    <= 2'b00;
            indrv_o    <= 2'b00;
          end
          if (w_req_edge) begin
            if (mode_sel_i == cur_mode_o) begin
              mode_ack_o <= 1'b1;
            end else begin
              state_q    <= S_QUIESCE;
              tgt_q      <= mode_sel_i;
              cnt_q      <= w_n_load;
              busy_o     <= 1'b1;
              txen_o     <= 1'b0;
              rxen_o     <= RXEN_OFF;
              tx_irstb_o <= 1'b0;
              rx_irstb_o <= 1'b0;
              ipdrv_o    <= 2'b00;
              indrv_o    <= 2'b00;
              iweakpu_o  <= w_wkpu;
              iweakpdn_o <= w_wkpd;
            end
          end
        end
        S_QUIESCE: begin
          iweakpu_o  <= w_wkpu;
          iweakpdn_o <= w_wkpd;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (tgt_q == C_MODE_OFF) begin
            state_q <= S_RELEASE;
          end else begin
            state_q <= S_ENABLE;
            cnt_q   <= w_n_load;
            if (tgt_q == C_MODE_TX) begin
              txen_o     <= 1'b1;
              ipdrv_o    <= drv_cfg_i[3:2];
              indrv_o    <= drv_cfg_i[1:0];
              iweakpu_o  <= 1'b0;
              iweakpdn_o <= 1'b0;
            end else begin
              rxen_o <= (tgt_q == C_MODE_RXD) ? RXEN_DAT : RXEN_CLK;
            end
          end
        end
        S_ENABLE: begin
          if (tgt_q == C_MODE_TX) begin
            ipdrv_o <= drv_cfg_i[3:2];
            indrv_o <= drv_cfg_i[1:0];
          end else begin
            iweakpu_o  <= w_wkpu;
            iweakpdn_o <= w_wkpd;
          end
          if (cnt_q == '0) begin
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RELEASE: begin
          mode_ack_o <= 1'b1;
          busy_o     <= 1'b0;
          cur_mode_o <= tgt_q;
          tx_irstb_o <= (tgt_q == C_MODE_TX);
          rx_irstb_o <= tgt_q[1];
          state_q    <= (tgt_q == C_MODE_OFF) ? S_OFF : S_ACTIVE;
        end
        default: state_q <= S_POR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_itrx_aib_phy_io_buf_seq.sv
`default_nettype none
// Directed bench for itrx_aib_phy_io_buf_seq: mode changes, POR abort, same-mode and busy requests.
module tb_itrx_aib_phy_io_buf_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       por_vcc_io, por_vcc_dig;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic [7:0] settle_cyc;
  logic       wkpu_cfg, wkpd_cfg;
  logic [3:0] drv_cfg;
  logic       txen, iweakpu, iweakpdn, tx_irstb, rx_irstb, mode_ack, busy;
  logic [2:0] rxen;
  logic [1:0] ipdrv, indrv, cur_mode;

  int errs   = 0;
  int checks = 0;
  int ack_cnt = 0;
  int ack_base;
  logic excl_viol = 1'b0;

  itrx_aib_phy_io_buf_seq dut (
    .clk(clk), .rst(rst),
    .por_vcc_io_i(por_vcc_io), .por_vcc_dig_i(por_vcc_dig),
    .mode_req_i(mode_req), .mode_sel_i(mode_sel), .settle_cyc_i(settle_cyc),
    .wkpu_cfg_i(wkpu_cfg), .wkpd_cfg_i(wkpd_cfg), .drv_cfg_i(drv_cfg),
    .txen_o(txen), .rxen_o(rxen), .iweakpu_o(iweakpu), .iweakpdn_o(iweakpdn),
    .ipdrv_o(ipdrv), .indrv_o(indrv), .tx_irstb_o(tx_irstb), .rx_irstb_o(rx_irstb),
    .mode_ack_o(mode_ack), .busy_o(busy), .cur_mode_o(cur_mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mode_ack === 1'b1) ack_cnt++;
    if (txen === 1'b1 && rxen !== 3'b000) excl_viol = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; por_vcc_io = 1'b0; por_vcc_dig = 1'b0;
    mode_req = 1'b0; mode_sel = 2'b00; settle_cyc = 8'd4;
    wkpu_cfg = 1'b1; wkpd_cfg = 1'b0; drv_cfg = 4'h0;

    // Reset values
    step(2);
    chk("rst_txen", {7'd0, txen}, 8'd0);
    chk("rst_rxen", {5'd0, rxen}, 8'd0);
    chk("rst_wkpu", {7'd0, iweakpu}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd1);
    chk("rst_mode", {6'd0, cur_mode}, 8'd0);
    chk("rst_txrstb", {7'd0, tx_irstb}, 8'd0);
    chk("rst_ack", {7'd0, mode_ack}, 8'd0);

    // Power-up with N=4: idle after 5 edges
    rst = 1'b0;
    step(4);
    chk("pwrup_busy4", {7'd0, busy}, 8'd1);
    step(1);
    chk("pwrup_busy5", {7'd0, busy}, 8'd0);
    chk("pwrup_wkpu", {7'd0, iweakpu}, 8'd1);

    // OFF -> TX, N=3
    settle_cyc = 8'd3; drv_cfg = 4'hA; mode_sel = 2'b01; mode_req = 1'b1;
    step(1);
    chk("tx_q_busy", {7'd0, busy}, 8'd1);
    mode_req = 1'b0;
    step(2);
    chk("tx_q_txen", {7'd0, txen}, 8'd0);
    step(1);
    chk("tx_en_txen", {7'd0, txen}, 8'd1);
    chk("tx_en_ipdrv", {6'd0, ipdrv}, 8'd2);
    chk("tx_en_indrv", {6'd0, indrv}, 8'd2);
    chk("tx_en_wkpu", {7'd0, iweakpu}, 8'd0);
    chk("tx_en_rstb", {7'd0, tx_irstb}, 8'd0);
    step(3);
    chk("tx_e6_ack", {7'd0, mode_ack}, 8'd0);
    chk("tx_e6_rstb", {7'd0, tx_irstb}, 8'd0);
    step(1);
    chk("tx_rel_rstb", {7'd0, tx_irstb}, 8'd1);
    chk("tx_rel_ack", {7'd0, mode_ack}, 8'd1);
    chk("tx_rel_mode", {6'd0, cur_mode}, 8'd1);
    chk("tx_rel_rxrstb", {7'd0, rx_irstb}, 8'd0);
    chk("tx_rel_busy", {7'd0, busy}, 8'd0);
    step(1);
    chk("tx_ack_pulse", {7'd0, mode_ack}, 8'd0);

    // TX -> RX clock, N=2
    settle_cyc = 8'd2; mode_sel = 2'b11; mode_req = 1'b1;
    step(1);
    chk("rxc_q_txen", {7'd0, txen}, 8'd0);
    chk("rxc_q_rxen", {5'd0, rxen}, 8'd0);
    mode_req = 1'b0;
    step(1);
    chk("rxc_e1_rxen", {5'd0, rxen}, 8'd0);
    step(1);
    chk("rxc_en_rxen", {5'd0, rxen}, 8'd2);
    chk("rxc_en_txen", {7'd0, txen}, 8'd0);
    chk("rxc_en_rxrstb", {7'd0, rx_irstb}, 8'd0);
    chk("rxc_en_wkpu", {7'd0, iweakpu}, 8'd1);
    step(2);
    chk("rxc_e4_ack", {7'd0, mode_ack}, 8'd0);
    step(1);
    chk("rxc_rel_rxrstb", {7'd0, rx_irstb}, 8'd1);
    chk("rxc_rel_ack", {7'd0, mode_ack}, 8'd1);
    chk("rxc_rel_mode", {6'd0, cur_mode}, 8'd3);
    chk("rxc_rel_txrstb", {7'd0, tx_irstb}, 8'd0);

    // Live weak-pull follow in ACTIVE RX, pull-up priority
    wkpu_cfg = 1'b0; wkpd_cfg = 1'b1;
    step(1);
    chk("live_wkpu0", {7'd0, iweakpu}, 8'd0);
    chk("live_wkpd1", {7'd0, iweakpdn}, 8'd1);
    wkpu_cfg = 1'b1;
    step(1);
    chk("live_prio_pu", {7'd0, iweakpu}, 8'd1);
    chk("live_prio_pd", {7'd0, iweakpdn}, 8'd0);
    wkpd_cfg = 1'b0;

    // POR pulse during ENABLE aborts the change
    settle_cyc = 8'd3; mode_sel = 2'b01; mode_req = 1'b1;
    ack_base = ack_cnt;
    step(1);
    mode_req = 1'b0;
    step(3);
    chk("por_pre_txen", {7'd0, txen}, 8'd1);
    por_vcc_io = 1'b1;
    step(1);
    por_vcc_io = 1'b0;
    chk("por_txen", {7'd0, txen}, 8'd0);
    chk("por_busy", {7'd0, busy}, 8'd1);
    chk("por_mode", {6'd0, cur_mode}, 8'd0);
    chk("por_rxrstb", {7'd0, rx_irstb}, 8'd0);
    chk("por_wkpu", {7'd0, iweakpu}, 8'd0);
    step(3);
    chk("por_pwrup_busy", {7'd0, busy}, 8'd1);
    step(1);
    chk("por_done_busy", {7'd0, busy}, 8'd0);
    chk("por_done_mode", {6'd0, cur_mode}, 8'd0);
    chk("por_done_wkpu", {7'd0, iweakpu}, 8'd1);
    chk("por_no_ack", ack_cnt - ack_base, 8'd0);

    // Same-mode request with settle 0: immediate ack
    settle_cyc = 8'd0; mode_sel = 2'b00; mode_req = 1'b1;
    step(1);
    chk("same_ack", {7'd0, mode_ack}, 8'd1);
    chk("same_busy", {7'd0, busy}, 8'd0);
    chk("same_wkpu", {7'd0, iweakpu}, 8'd1);
    mode_req = 1'b0;
    step(1);
    chk("same_ack_end", {7'd0, mode_ack}, 8'd0);

    // Second request edge while busy is dropped
    ack_base = ack_cnt;
    mode_sel = 2'b01; mode_req = 1'b1;
    step(1);
    chk("busy_req_busy", {7'd0, busy}, 8'd1);
    mode_req = 1'b0;
    step(1);
    mode_req = 1'b1; mode_sel = 2'b10;
    step(1);
    mode_req = 1'b0;
    step(1);
    chk("busy_req_ack", {7'd0, mode_ack}, 8'd1);
    chk("busy_req_mode", {6'd0, cur_mode}, 8'd1);
    step(5);
    chk("busy_req_one_ack", ack_cnt - ack_base, 8'd1);
    chk("busy_req_idle", {7'd0, busy}, 8'd0);

    chk("txen_rxen_excl", {7'd0, excl_viol}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
